// File: rtl/fifo_flag_gen_pkg.sv
// Shared constants and types for the FIFO status-flag generator.
// Holds the default address width, depth derivation, level width and
// the reset-time almost-full / almost-empty thresholds.
package fifo_flag_gen_pkg;

  localparam int unsigned FLAG_ADDR_W     = 4;
  localparam int unsigned FLAG_DEPTH      = 32'd1 << FLAG_ADDR_W;
  localparam int unsigned FLAG_LVL_W      = FLAG_ADDR_W + 1;
  localparam int unsigned FLAG_AF_DEFAULT = FLAG_DEPTH - 2;
  localparam int unsigned FLAG_AE_DEFAULT = 2;

  // Fill-state flags, all decoded from the same next-level value.
  typedef struct packed {
    logic full;
    logic empty;
    logic half;
    logic almost_full;
    logic almost_empty;
    logic healthy;
  } fill_flags_t;

  // Flag pattern held while reset is asserted.
  localparam fill_flags_t FLAGS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    half:         1'b0,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    healthy:      1'b0
  };

  // FIFO depth for a given address width.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_flag_gen_level_calc.sv
// fifo_level_calc: combinational next fill level from the binary
// write/read pointers (wrap bit in the MSB). A difference larger than
// DEPTH can only come from corrupted pointers; it is saturated to DEPTH
// and reported on o_illegal.
module fifo_level_calc
  import fifo_flag_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = FLAG_ADDR_W
) (
  input  logic [ADDR_W:0] i_wr_ptr,
  input  logic [ADDR_W:0] i_rd_ptr,
  output logic [ADDR_W:0] o_level,
  output logic            o_illegal
);

  localparam int unsigned LW    = ADDR_W + 1;
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [ADDR_W:0] w_diff;

  // Modulo-2^(ADDR_W+1) subtraction handles pointer wrap naturally.
  always_comb begin
    w_diff    = i_wr_ptr - i_rd_ptr;
    o_illegal = (w_diff > LW'(DEPTH));
    o_level   = o_illegal ? LW'(DEPTH) : w_diff;
  end

endmodule

// File: rtl/fifo_flag_gen.sv
// fifo_flag_gen: registered fill level, fill-state flags, programmable
// almost thresholds and sticky overflow/underflow error bits for the FIFO.
// Optional build macro: FLAG_PEAK_EN adds the peak_level high-water mark.
module fifo_flag_gen
  import fifo_flag_gen_pkg::*;
#(
  parameter int unsigned ADDR_W     = FLAG_ADDR_W,
  parameter int unsigned AF_DEFAULT = depth_of(ADDR_W) - 2,
  parameter int unsigned AE_DEFAULT = FLAG_AE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ADDR_W:0] b_wr_ptr,
  input  logic [ADDR_W:0] b_rd_ptr,
  input  logic            wr_req,
  input  logic            rd_req,
  input  logic            thr_load,
  input  logic [ADDR_W:0] af_thresh,
  input  logic [ADDR_W:0] ae_thresh,
  input  logic            clr_err,
  output logic [ADDR_W:0] level,
  output logic            f_full,
  output logic            f_empty,
  output logic            f_half,
  output logic            f_almost_full,
  output logic            f_almost_empty,
  output logic            f_healthy,
  output logic            f_overflow,
  output logic            f_underflow
`ifdef FLAG_PEAK_EN
  ,
  output logic [ADDR_W:0] peak_level
`endif
);

  localparam int unsigned LW    = ADDR_W + 1;
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [ADDR_W:0] w_lvl_nxt;
  logic            w_illegal;
  fill_flags_t     w_flags_nxt;
  logic            w_ovf_set;
  logic            w_unf_set;

  logic [ADDR_W:0] r_level;
  fill_flags_t     r_flags;
  logic [ADDR_W:0] r_af;
  logic [ADDR_W:0] r_ae;
  logic            r_ovf;
  logic            r_unf;

  fifo_level_calc #(
    .ADDR_W (ADDR_W)
  ) u_level_calc (
    .i_wr_ptr  (b_wr_ptr),
    .i_rd_ptr  (b_rd_ptr),
    .o_level   (w_lvl_nxt),
    .o_illegal (w_illegal)
  );

  // Decode every flag from the next level so they register together with it.
  always_comb begin
    w_flags_nxt              = '0;
    w_flags_nxt.full         = (w_lvl_nxt == LW'(DEPTH));
    w_flags_nxt.empty        = (w_lvl_nxt == '0);
    w_flags_nxt.half         = (w_lvl_nxt >= LW'(DEPTH / 2));
    w_flags_nxt.almost_full  = (w_lvl_nxt >= r_af);
    w_flags_nxt.almost_empty = (w_lvl_nxt <= r_ae);
    w_flags_nxt.healthy      = !(w_flags_nxt.full | w_flags_nxt.empty |
                                 w_flags_nxt.almost_full |
                                 w_flags_nxt.almost_empty);
  end

  // Error set conditions use the registered full/empty state the requester saw.
  always_comb begin
    w_ovf_set = w_illegal | (wr_req & ~rd_req & r_flags.full);
    w_unf_set = rd_req & r_flags.empty;
  end

  // Level, flags and thresholds; a new threshold affects flags from the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
      r_flags <= FLAGS_RST;
      r_af    <= LW'(AF_DEFAULT);
      r_ae    <= LW'(AE_DEFAULT);
    end else begin
      r_level <= w_lvl_nxt;
      r_flags <= w_flags_nxt;
      if (thr_load) begin
        r_af <= af_thresh;
        r_ae <= ae_thresh;
      end
    end
  end

  // Sticky error bits; a set in the same cycle as clr_err takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
      r_unf <= w_unf_set | (r_unf & ~clr_err);
    end
  end

`ifdef FLAG_PEAK_EN
  logic [ADDR_W:0] r_peak;
  logic [ADDR_W:0] w_peak_nxt;

  // High-water mark; clr_err restarts tracking from the incoming level.
  always_comb begin
    w_peak_nxt = r_peak;
    if (clr_err) begin
      w_peak_nxt = w_lvl_nxt;
    end else if (w_lvl_nxt > r_peak) begin
      w_peak_nxt = w_lvl_nxt;
    end
  end

  // Peak register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak <= '0;
    end else begin
      r_peak <= w_peak_nxt;
    end
  end

  assign peak_level = r_peak;
`endif

  assign level          = r_level;
  assign f_full         = r_flags.full;
  assign f_empty        = r_flags.empty;
  assign f_half         = r_flags.half;
  assign f_almost_full  = r_flags.almost_full;
  assign f_almost_empty = r_flags.almost_empty;
  assign f_healthy      = r_flags.healthy;
  assign f_overflow     = r_ovf;
  assign f_underflow    = r_unf;

endmodule

// File: tb/tb_fifo_flag_gen.sv
// Directed bench for fifo_flag_gen with ADDR_W=4 (DEPTH=16, af=14, ae=2).
// Status vector layout: {level[4:0], full, empty, half, almost_full,
// almost_empty, healthy}.
module tb_fifo_flag_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] b_wr_ptr;
  logic [4:0] b_rd_ptr;
  logic       wr_req;
  logic       rd_req;
  logic       thr_load;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;
  logic       clr_err;
  logic [4:0] level;
  logic       f_full;
  logic       f_empty;
  logic       f_half;
  logic       f_almost_full;
  logic       f_almost_empty;
  logic       f_healthy;
  logic       f_overflow;
  logic       f_underflow;
`ifdef FLAG_PEAK_EN
  logic [4:0] peak_level;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [10:0] obs;
  assign obs = {level, f_full, f_empty, f_half, f_almost_full,
                f_almost_empty, f_healthy};

  always #5 clk = ~clk;

  fifo_flag_gen #(
    .ADDR_W     (4),
    .AF_DEFAULT (14),
    .AE_DEFAULT (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .b_wr_ptr       (b_wr_ptr),
    .b_rd_ptr       (b_rd_ptr),
    .wr_req         (wr_req),
    .rd_req         (rd_req),
    .thr_load       (thr_load),
    .af_thresh      (af_thresh),
    .ae_thresh      (ae_thresh),
    .clr_err        (clr_err),
    .level          (level),
    .f_full         (f_full),
    .f_empty        (f_empty),
    .f_half         (f_half),
    .f_almost_full  (f_almost_full),
    .f_almost_empty (f_almost_empty),
    .f_healthy      (f_healthy),
    .f_overflow     (f_overflow),
    .f_underflow    (f_underflow)
`ifdef FLAG_PEAK_EN
    ,
    .peak_level     (peak_level)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; b_wr_ptr = 5'd9; b_rd_ptr = 5'd0;
    wr_req = 1'b1; rd_req = 1'b1; thr_load = 1'b0;
    af_thresh = '0; ae_thresh = '0; clr_err = 1'b0;
    step(); step();
    n_cmp++;
    if (obs !== {5'd0, 6'b010010}) begin
      n_bad++; $display("FAIL reset_hold status got %b want %b", obs, {5'd0, 6'b010010});
    end
    n_cmp++;
    if ({f_overflow, f_underflow} !== 2'b00) begin
      n_bad++; $display("FAIL reset_hold errors got %b want 00", {f_overflow, f_underflow});
    end
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; b_wr_ptr = 5'd0;
    step();
    n_cmp++;
    if (obs !== {5'd0, 6'b010010}) begin
      n_bad++; $display("FAIL reset_idle status got %b want %b", obs, {5'd0, 6'b010010});
    end
    n_cmp++;
    if ({f_overflow, f_underflow} !== 2'b00) begin
      n_bad++; $display("FAIL reset_idle errors got %b want 00", {f_overflow, f_underflow});
    end
  endtask

  task automatic test_fill();
    logic [10:0] exp_v;
    for (int w = 0; w <= 16; w++) begin
      b_wr_ptr = 5'(w); b_rd_ptr = 5'd0;
      #1;
      if (w > 0) begin
        n_cmp++;
        if (level !== 5'(w - 1)) begin
          n_bad++; $display("FAIL fill_latency w=%0d level got %0d want %0d", w, level, w - 1);
        end
      end
      step();
      exp_v = {5'(w), (w == 16), (w == 0), (w >= 8), (w >= 14), (w <= 2),
               (w >= 3 && w <= 13)};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++; $display("FAIL fill w=%0d status got %b want %b", w, obs, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    b_wr_ptr = 5'b00011; b_rd_ptr = 5'b10011;
    step();
    n_cmp++;
    if (obs !== {5'd16, 6'b101100}) begin
      n_bad++; $display("FAIL wrap_full status got %b want %b", obs, {5'd16, 6'b101100});
    end
    b_rd_ptr = 5'b11101;
    step();
    n_cmp++;
    if (obs !== {5'd6, 6'b000001}) begin
      n_bad++; $display("FAIL wrap_six status got %b want %b", obs, {5'd6, 6'b000001});
    end
  endtask

  task automatic test_overflow();
    clr_err = 1'b1; b_wr_ptr = 5'd16; b_rd_ptr = 5'd0;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if (f_overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_pre got %b want 0", f_overflow);
    end
    wr_req = 1'b1; rd_req = 1'b1;
    step();
    n_cmp++;
    if (f_overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_wr_rd_full got %b want 0", f_overflow);
    end
    rd_req = 1'b0;
    step();
    n_cmp++;
    if (f_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set got %b want 1", f_overflow);
    end
    wr_req = 1'b0;
    step();
    n_cmp++;
    if (f_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_sticky got %b want 1", f_overflow);
    end
    wr_req = 1'b1; clr_err = 1'b1;
    step();
    n_cmp++;
    if (f_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set_beats_clr got %b want 1", f_overflow);
    end
    wr_req = 1'b0;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if (f_overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clr got %b want 0", f_overflow);
    end
    n_cmp++;
    if (f_underflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_no_unf got %b want 0", f_underflow);
    end
  endtask

  task automatic test_underflow();
    b_wr_ptr = 5'd5; b_rd_ptr = 5'd5;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (f_underflow !== 1'b1) begin
      n_bad++; $display("FAIL unf_set got %b want 1", f_underflow);
    end
    step();
    n_cmp++;
    if (f_underflow !== 1'b1) begin
      n_bad++; $display("FAIL unf_sticky got %b want 1", f_underflow);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if (f_underflow !== 1'b0) begin
      n_bad++; $display("FAIL unf_clr got %b want 0", f_underflow);
    end
    rd_req = 1'b1; wr_req = 1'b1;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    n_cmp++;
    if ({f_underflow, f_overflow} !== 2'b10) begin
      n_bad++; $display("FAIL unf_rd_wr_empty got %b want 10", {f_underflow, f_overflow});
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    b_wr_ptr = 5'd6;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    n_cmp++;
    if (f_underflow !== 1'b0) begin
      n_bad++; $display("FAIL unf_read_nonempty got %b want 0", f_underflow);
    end
  endtask

  task automatic test_illegal();
    b_wr_ptr = 5'd20; b_rd_ptr = 5'd0;
    step();
    n_cmp++;
    if ({obs, f_overflow} !== {5'd16, 6'b101100, 1'b1}) begin
      n_bad++; $display("FAIL illegal_sat got %b want %b", {obs, f_overflow}, {5'd16, 6'b101100, 1'b1});
    end
    b_wr_ptr = 5'd4; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if ({obs, f_overflow} !== {5'd4, 6'b000001, 1'b0}) begin
      n_bad++; $display("FAIL illegal_recover got %b want %b", {obs, f_overflow}, {5'd4, 6'b000001, 1'b0});
    end
  endtask

  task automatic test_thresholds();
    b_wr_ptr = 5'd7; b_rd_ptr = 5'd0;
    step();
    thr_load = 1'b1; af_thresh = 5'd10; ae_thresh = 5'd5;
    step();
    thr_load = 1'b0;
    n_cmp++;
    if (obs !== {5'd7, 6'b000001}) begin
      n_bad++; $display("FAIL thr_load_l7 status got %b want %b", obs, {5'd7, 6'b000001});
    end
    step();
    n_cmp++;
    if (obs !== {5'd7, 6'b000001}) begin
      n_bad++; $display("FAIL thr_new_l7 status got %b want %b", obs, {5'd7, 6'b000001});
    end
    b_wr_ptr = 5'd10;
    step();
    n_cmp++;
    if (obs !== {5'd10, 6'b001100}) begin
      n_bad++; $display("FAIL thr_af10_l10 status got %b want %b", obs, {5'd10, 6'b001100});
    end
    b_wr_ptr = 5'd9;
    step();
    n_cmp++;
    if (obs !== {5'd9, 6'b001001}) begin
      n_bad++; $display("FAIL thr_af10_l9 status got %b want %b", obs, {5'd9, 6'b001001});
    end
    thr_load = 1'b1; af_thresh = 5'd9;
    step();
    thr_load = 1'b0;
    n_cmp++;
    if (obs !== {5'd9, 6'b001001}) begin
      n_bad++; $display("FAIL thr_old_at_load status got %b want %b", obs, {5'd9, 6'b001001});
    end
    step();
    n_cmp++;
    if (obs !== {5'd9, 6'b001100}) begin
      n_bad++; $display("FAIL thr_af9_next status got %b want %b", obs, {5'd9, 6'b001100});
    end
    thr_load = 1'b1; af_thresh = 5'd0; ae_thresh = 5'd16; b_wr_ptr = 5'd0;
    step();
    thr_load = 1'b0;
    n_cmp++;
    if (obs !== {5'd0, 6'b010010}) begin
      n_bad++; $display("FAIL thr_extreme_load status got %b want %b", obs, {5'd0, 6'b010010});
    end
    step();
    n_cmp++;
    if (obs !== {5'd0, 6'b010110}) begin
      n_bad++; $display("FAIL thr_af0_l0 status got %b want %b", obs, {5'd0, 6'b010110});
    end
    b_wr_ptr = 5'd8;
    step();
    n_cmp++;
    if (obs !== {5'd8, 6'b001110}) begin
      n_bad++; $display("FAIL thr_ae16_l8 status got %b want %b", obs, {5'd8, 6'b001110});
    end
  endtask

  task automatic test_reset_mid();
    b_wr_ptr = 5'd16; b_rd_ptr = 5'd0;
    step();
    wr_req = 1'b1;
    step();
    reset = 1'b1; rd_req = 1'b1; thr_load = 1'b1; af_thresh = 5'd3; ae_thresh = 5'd15;
    step();
    n_cmp++;
    if ({obs, f_overflow, f_underflow} !== {5'd0, 6'b010010, 2'b00}) begin
      n_bad++; $display("FAIL reset_mid got %b want %b", {obs, f_overflow, f_underflow}, {5'd0, 6'b010010, 2'b00});
    end
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; thr_load = 1'b0; b_wr_ptr = 5'd13;
    step();
    n_cmp++;
    if (obs !== {5'd13, 6'b001001}) begin
      n_bad++; $display("FAIL reset_mid_defaults status got %b want %b", obs, {5'd13, 6'b001001});
    end
  endtask

`ifdef FLAG_PEAK_EN
  task automatic test_peak();
    reset = 1'b1; b_wr_ptr = 5'd0; b_rd_ptr = 5'd0;
    step();
    reset = 1'b0;
    n_cmp++;
    if (peak_level !== 5'd0) begin
      n_bad++; $display("FAIL peak_reset got %0d want 0", peak_level);
    end
    for (int w = 1; w <= 12; w++) begin
      b_wr_ptr = 5'(w);
      step();
    end
    for (int r = 1; r <= 8; r++) begin
      b_rd_ptr = 5'(r);
      step();
    end
    n_cmp++;
    if ({level, peak_level} !== {5'd4, 5'd12}) begin
      n_bad++; $display("FAIL peak_hold level/peak got %0d/%0d want 4/12", level, peak_level);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_cmp++;
    if (peak_level !== 5'd4) begin
      n_bad++; $display("FAIL peak_clr got %0d want 4", peak_level);
    end
    b_wr_ptr = 5'd14;
    step();
    n_cmp++;
    if (peak_level !== 5'd6) begin
      n_bad++; $display("FAIL peak_regrow got %0d want 6", peak_level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_overflow();
    test_underflow();
    test_illegal();
    test_thresholds();
    test_reset_mid();
`ifdef FLAG_PEAK_EN
    test_peak();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
